// File: rtl/uart_spi_cmd.sv
// UART command to SPI register access bridge: [rw|addr7] (+wdata) -> SPI -> reply.
// Define UART_SPI_CMD_WRITE_ACK_EN to answer completed writes with 8'hA5.
module uart_spi_cmd #(
  parameter logic [31:0] BYTE_TIMEOUT = 32'd1_000_000,
  parameter logic [31:0] SPI_TIMEOUT  = 32'd10_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       spi_en,
  output logic       spi_rw,
  output logic [6:0] spi_addr,
  output logic [7:0] spi_wdata,
  input  logic [7:0] spi_rdata,
  input  logic       spi_done,
  output logic       busy,
  output logic       err,
  output logic       rx_drop
);

  typedef enum logic [1:0] {
    IDLE,
    GET_DATA,
    SPI_RUN,
    TX_RESP
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] timer;
  logic [31:0] timer_d;
  logic        done_q;
  logic        done_rise;
  logic        byte_to;
  logic        spi_to;
  logic        byte_ok;
  logic        rw_d;
  logic [6:0]  addr_d;
  logic [7:0]  wdata_d;
  logic [7:0]  tx_data_d;
  logic        err_d;
  logic        rx_drop_d;

  // Only a fresh rising edge counts; a level left high by the
  // previous transfer must not complete the new one.
  assign done_rise = spi_done & ~done_q;
  assign byte_to = ({1'b0, timer} + 33'd1) >= {1'b0, BYTE_TIMEOUT};
  assign spi_to  = ({1'b0, timer} + 33'd1) >= {1'b0, SPI_TIMEOUT};
  assign busy    = (state != IDLE);

  always_comb begin
    state_d   = state;
    rw_d      = spi_rw;
    addr_d    = spi_addr;
    wdata_d   = spi_wdata;
    tx_data_d = tx_data;
    err_d     = 1'b0;
    rx_drop_d = 1'b0;
    byte_ok   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          byte_ok = 1'b1;
          rw_d    = rx_data[7];
          addr_d  = rx_data[6:0];
          state_d = rx_data[7] ? SPI_RUN : GET_DATA;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          byte_ok = 1'b1;
          wdata_d = rx_data;
          state_d = SPI_RUN;
        end else if (byte_to) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      SPI_RUN: begin
        rx_drop_d = rx_valid;
        if (done_rise) begin
          if (spi_rw) begin
            tx_data_d = spi_rdata;
            state_d   = TX_RESP;
          end else begin
`ifdef UART_SPI_CMD_WRITE_ACK_EN
            tx_data_d = 8'hA5;
            state_d   = TX_RESP;
`else
            state_d   = IDLE;
`endif
          end
        end else if (spi_to) begin
          err_d     = 1'b1;
          tx_data_d = 8'hEE;
          state_d   = TX_RESP;
        end
      end
      TX_RESP: begin
        rx_drop_d = rx_valid;
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer;
    if ((state_d != state) || byte_ok || (state == IDLE)) begin
      timer_d = 32'd0;
    end else if (timer != 32'hFFFF_FFFF) begin
      timer_d = timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= 32'd0;
      done_q    <= 1'b0;
      spi_en    <= 1'b0;
      spi_rw    <= 1'b0;
      spi_addr  <= 7'd0;
      spi_wdata <= 8'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      err       <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      done_q    <= spi_done;
      // Enable waits one cycle after entry so it is always low
      // for at least one clock between transfers.
      spi_en    <= (state == SPI_RUN) && (state_d == SPI_RUN);
      spi_rw    <= rw_d;
      spi_addr  <= addr_d;
      spi_wdata <= wdata_d;
      tx_valid  <= (state_d == TX_RESP);
      tx_data   <= tx_data_d;
      err       <= err_d;
      rx_drop   <= rx_drop_d;
    end
  end

endmodule

// File: doc/uart_spi_cmd.md
UART_SPI_CMD -- requirements
Module: uart_spi_cmd

Interface
REQ-001 Parameter BYTE_TIMEOUT, default 32'd1_000_000; clk cycles allowed between command bytes before abort.
REQ-002 Parameter SPI_TIMEOUT, default 32'd10_000; clk cycles allowed for one SPI transfer before abort.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_data  input  8  byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 tx_data  output  8  response byte to UART transmitter.
REQ-008 tx_valid  output  1  tx_data valid; held until accepted.
REQ-009 tx_ready  input  1  transmitter accepts when tx_valid&tx_ready.
REQ-010 spi_en  output  1  level enable to SPI master; high for whole transfer.
REQ-011 spi_rw  output  1  1=read, 0=write.
REQ-012 spi_addr  output  7  SPI register address.
REQ-013 spi_wdata  output  8  SPI write data.
REQ-014 spi_rdata  input  8  SPI read data, valid once spi_done rises.
REQ-015 spi_done  input  1  SPI completion level; stays high until next transfer starts.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  one-cycle pulse on any timeout abort.
REQ-018 rx_drop  output  1  one-cycle pulse when rx_valid arrives in a state that cannot accept it.

Function
REQ-019 FSM states: IDLE, GET_DATA, SPI_RUN, TX_RESP.
REQ-020 IDLE + rx_valid: latch rw=rx_data[7], addr=rx_data[6:0]; rw=1 -> SPI_RUN, rw=0 -> GET_DATA.
REQ-021 GET_DATA + rx_valid: latch wdata=rx_data -> SPI_RUN; timer reaching BYTE_TIMEOUT -> pulse err, -> IDLE, no SPI access.
REQ-022 SPI_RUN: spi_en=1, spi_rw/spi_addr/spi_wdata stable from latched values for whole state.
REQ-023 Completion = 0->1 edge of spi_done sampled in SPI_RUN (registered previous value); a level already high on entry is not completion.
REQ-024 On completion: spi_en=0 next cycle; read -> tx_data=spi_rdata, -> TX_RESP; write -> per REQ-033/034.
REQ-025 SPI_RUN timer reaching SPI_TIMEOUT: spi_en=0, pulse err, tx_data=8'hEE, -> TX_RESP.
REQ-026 TX_RESP: tx_valid=1, tx_data constant; on tx_valid&tx_ready -> tx_valid=0, -> IDLE same edge; no timeout.
REQ-027 Timers: 32-bit, clear on every state entry and on each accepted byte; saturate, never wrap.
REQ-028 rx_valid in SPI_RUN or TX_RESP: byte discarded, rx_drop pulse, FSM unaffected.
REQ-029 spi_en low for at least one clk between consecutive transfers (SPI master counter reset).
REQ-030 Latency: read command byte accepted at edge N -> spi_en high after edge N+1.

Reset
REQ-031 rst_n low at posedge clk: state=IDLE, spi_en=0, spi_rw=0, spi_addr=0, spi_wdata=0, tx_valid=0, tx_data=0, busy=0, err=0, rx_drop=0, timers=0; applies mid-transfer, spi_en drops next edge.
REQ-032 No asynchronous reset path; rst_n sampled only on posedge clk.

Configuration
REQ-033 Macro UART_SPI_CMD_WRITE_ACK_EN defined: write completion -> tx_data=8'hA5, -> TX_RESP.
REQ-034 Macro undefined: write completion -> IDLE directly, no tx_valid; SPI timeout still sends 8'hEE.

Verification
REQ-035 Read: rx 8'h85 -> spi_en=1, spi_rw=1, spi_addr=7'h05; drive spi_rdata=8'h3C, spi_done 0->1 -> tx_data=8'h3C, tx_valid until tx_ready, busy=0 after.
REQ-036 Write: rx 8'h12 then 8'hC7 -> spi_rw=0, spi_addr=7'h12, spi_wdata=8'hC7; done edge -> ACK_EN: tx 8'hA5; else no tx, IDLE.
REQ-037 Stale done: spi_done held high from prior transfer, rx 8'h81 -> spi_en stays high until done falls and rises again.
REQ-038 Timeouts (BYTE_TIMEOUT=16, SPI_TIMEOUT=20): rx 8'h10 only -> err pulse at cycle 16, no spi_en; read, no done -> err, spi_en=0, tx 8'hEE.
REQ-039 rx_valid during SPI_RUN -> rx_drop pulse, latched addr unchanged; rst_n low during SPI_RUN -> spi_en=0, busy=0 next edge.
